// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the bus-to-UART request bridge: FSM states,
// frame mode encoding and the UART frame width helper.
package bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // UART frame layout is {addr, wdata, mode}
  function automatic int unsigned frame_width(input int unsigned aw, input int unsigned dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/bus_bridge_txq_fifo.sv
// bridge_req_fifo: synchronous request queue with level output.
// DEPTH must be a power of two so the pointers wrap naturally.
module bridge_req_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  // full is taken from the registered level, so a same-cycle pop never frees a slot
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // storage array; entries are only read after being written
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // pointers and level; simultaneous push/pop leaves the level unchanged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/bus_bridge_txq.sv
// bus_bridge_txq: queues slave-port read/write requests and ships them as
// UART frames; read responses come back as single UART RX bytes.
// Optional read timeout compiled in with `define BUS_BRIDGE_RD_TIMEOUT_EN.
module bus_bridge_txq
  import bus_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 65535
) (
  input  logic                                            clk,
  input  logic                                            rstn,
  input  logic                                            smemwen,
  input  logic                                            smemren,
  input  logic [ADDR_WIDTH-1:0]                           smemaddr,
  input  logic [DATA_WIDTH-1:0]                           smemwdata,
  output logic                                            req_ready,
  output logic [DATA_WIDTH-1:0]                           smemrdata,
  output logic                                            rvalid,
  output logic [frame_width(ADDR_WIDTH, DATA_WIDTH)-1:0]  u_din,
  output logic                                            u_en,
  input  logic                                            u_tx_busy,
  input  logic                                            u_rx_ready,
  input  logic [DATA_WIDTH-1:0]                           u_dout,
  output logic [$clog2(FIFO_DEPTH):0]                     fifo_level,
  output logic                                            rd_timeout
);

  localparam int unsigned FW = frame_width(ADDR_WIDTH, DATA_WIDTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_busy_seen;
  logic                w_busy_seen_nxt;
  logic                r_is_rd;
  logic                w_is_rd_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FW-1:0]       w_entry;
  logic [FW-1:0]       w_head;
  logic                w_rvalid_nxt;
  logic                w_tmo_nxt;
  logic                w_rdata_ld;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                w_tmo_hit;

  // write wins over read when both strobes are high
  assign w_push    = smemwen | smemren;
  assign w_entry   = smemwen ? {smemaddr, smemwdata, MODE_WRITE}
                             : {smemaddr, DATA_WIDTH'(0), MODE_READ};
  assign req_ready = ~w_full;

  bridge_req_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

`ifdef BUS_BRIDGE_RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // terminal cycle is the RD_TIMEOUT-th cycle spent in WAIT_RD
  assign w_tmo_hit = (r_tmo_cnt == TW'(RD_TIMEOUT - 1));

  // cycles waited for the current read response; idle at zero elsewhere
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_WAIT_RD && !u_rx_ready && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  // timeout compiled out: the condition can never be met
  assign w_tmo_hit = (RD_TIMEOUT < 0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_busy_seen <= 1'b0;
      r_is_rd     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy_seen <= w_busy_seen_nxt;
      r_is_rd     <= w_is_rd_nxt;
    end
  end

  // next-state and pulse decode
  always_comb begin
    w_state_nxt     = r_state;
    w_busy_seen_nxt = r_busy_seen;
    w_is_rd_nxt     = r_is_rd;
    w_pop           = 1'b0;
    w_rvalid_nxt    = 1'b0;
    w_tmo_nxt       = 1'b0;
    w_rdata_ld      = 1'b0;
    w_rdata_nxt     = u_dout;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty && !u_tx_busy) begin
          w_pop           = 1'b1;
          w_is_rd_nxt     = (w_head[0] == MODE_READ);
          w_busy_seen_nxt = 1'b0;
          w_state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        // transmission is over once busy has been seen rising and then falling
        if (u_tx_busy) begin
          w_busy_seen_nxt = 1'b1;
        end else if (r_busy_seen) begin
          w_state_nxt = r_is_rd ? ST_WAIT_RD : ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (u_rx_ready) begin
          w_rdata_ld   = 1'b1;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_rdata_ld   = 1'b1;
          w_rdata_nxt  = '1;
          w_rvalid_nxt = 1'b1;
          w_tmo_nxt    = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // registered UART frame, start pulse and read-response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u_din      <= '0;
      u_en       <= 1'b0;
      rvalid     <= 1'b0;
      rd_timeout <= 1'b0;
      smemrdata  <= '0;
    end else begin
      u_en       <= w_pop;
      rvalid     <= w_rvalid_nxt;
      rd_timeout <= w_tmo_nxt;
      if (w_pop)      u_din     <= w_head;
      if (w_rdata_ld) smemrdata <= w_rdata_nxt;
    end
  end

endmodule

// File: doc/bus_bridge_txq.md
BUS_BRIDGE_TXQ -- requirements
Module: bus_bridge_txq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bus data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, bus address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RD_TIMEOUT, default 65535, maximum wait in cycles for a UART read response.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- smemwen  in  1  write request from slave port.
- smemren  in  1  read request from slave port.
- smemaddr  in  ADDR_WIDTH  request address.
- smemwdata  in  DATA_WIDTH  write data.
- req_ready  out  1  request accepted this cycle.
- smemrdata  out  DATA_WIDTH  read data.
- rvalid  out  1  read data valid pulse.
- u_din  out  ADDR_WIDTH+DATA_WIDTH+1  UART TX frame.
- u_en  out  1  UART TX start pulse.
- u_tx_busy  in  1  UART transmitter busy.
- u_rx_ready  in  1  UART RX byte valid pulse.
- u_dout  in  DATA_WIDTH  UART RX byte.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries.
- rd_timeout  out  1  read timeout pulse.

Function
REQ-006 SHALL assert req_ready whenever the registered FIFO is not full; a request is enqueued when (smemwen|smemren)&req_ready.
REQ-007 SHALL ignore smemren when smemwen and smemren are both high in the same cycle: the entry is a write.
REQ-008 SHALL store each entry as {addr, wdata, mode}, with mode=1 for write and mode=0 for read; read entries store wdata=0.
REQ-009 SHALL drop a request presented while full; full is not relieved by a same-cycle pop.
REQ-010 SHALL use FSM states IDLE, SEND and WAIT_RD:
- IDLE -> SEND when the FIFO is non-empty and !u_tx_busy. The FSM pops the head entry, registers it on u_din and pulses u_en for exactly one cycle.
- SEND waits for u_tx_busy to be seen high and then low.
- SEND -> WAIT_RD if the frame was a read, else SEND -> IDLE.
- WAIT_RD -> IDLE on u_rx_ready. The FSM registers u_dout onto smemrdata and pulses rvalid for one cycle (one-cycle latency).
REQ-011 SHALL hold u_din stable from the u_en pulse until the next pop.
REQ-012 SHALL discard u_rx_ready pulses outside WAIT_RD with no output effect.
REQ-013 SHALL handle push and pop in the same cycle with fifo_level unchanged and correct pointer wrap modulo FIFO_DEPTH.
REQ-014 SHALL hold smemrdata at its last value when rvalid is low.

Reset
REQ-015 SHALL on rstn low immediately clear:
- FSM to IDLE
- FIFO pointers and fifo_level to 0
- u_din, smemrdata to 0
- u_en, rvalid, rd_timeout to 0
- timeout counter to 0
REQ-016 SHALL discard queued entries and any outstanding read on reset mid-operation; no rvalid follows reset.

Configuration
REQ-017 SHALL compile the read timeout only when macro BUS_BRIDGE_RD_TIMEOUT_EN is defined.
REQ-018 SHALL, with the macro defined, count cycles in WAIT_RD:
- On reaching RD_TIMEOUT without u_rx_ready, pulse rd_timeout and rvalid for one cycle, drive smemrdata all-ones, and return to IDLE.
- u_rx_ready on the terminal cycle wins over the timeout.
REQ-019 SHALL, without the macro, wait indefinitely in WAIT_RD and tie rd_timeout to 0.

Structure
REQ-020 SHALL place the FSM state enum, the mode encoding (MODE_READ=0, MODE_WRITE=1) and the frame-width function in shared package bus_bridge_pkg.
REQ-021 SHALL implement the queue as sub-module bridge_req_fifo (sync FIFO with level output); the FSM and timeout stay in bus_bridge_txq.

Verification
REQ-022 SHALL cover a single write:
- Stimulus: addr=0x123, wdata=0xA5 with smemwen.
- Response: u_en pulses once with u_din={0x123,0xA5,1}; fifo_level returns to 0; no rvalid.
REQ-023 SHALL cover a read:
- Stimulus: addr=0x0F0 with smemren; u_rx_ready with u_dout=0x3C after the TX completes.
- Response: u_din={0x0F0,0x00,0}; rvalid one cycle later with smemrdata=0x3C.
REQ-024 SHALL cover overflow:
- Stimulus: five back-to-back writes with FIFO_DEPTH=4 while u_tx_busy is held high.
- Response: fifo_level=4; req_ready low on the fifth write; the fifth write is dropped; four frames are sent in order after busy falls.
REQ-025 SHALL cover the timeout with BUS_BRIDGE_RD_TIMEOUT_EN and RD_TIMEOUT=16:
- Stimulus: a read with no response.
- Response: after 16 WAIT_RD cycles, rd_timeout and rvalid pulse with smemrdata=0xFF; the FSM returns to IDLE.
REQ-026 SHALL cover simultaneous requests and stray RX:
- Stimulus: smemwen and smemren together.
- Response: one write frame only.
- Stimulus: stray u_rx_ready in IDLE.
- Response: no rvalid.
REQ-027 SHALL cover reset mid-read:
- Stimulus: rstn low in WAIT_RD with 2 entries queued.
- Response: all outputs zero; fifo_level=0; no later u_en or rvalid.
